// File: rtl/serial_deser.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Define SERIAL_DESER_PARITY_EN to add the parity bit between data and stop.
module serial_deser #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             msb_first,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SERIAL_DESER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [1:0]       sync;
    logic             s;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] sbuf;
    logic             msb_l;
    logic             fin_ok;
    logic             fin_err;
    logic             stop_good;

    assign s    = sync[1];
    assign busy = (state != IDLE);

`ifdef SERIAL_DESER_PARITY_EN
    logic par_err;
    assign stop_good = s && !par_err;
`else
    assign stop_good = s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sync      <= 2'b11;
            cnt       <= '0;
            bcnt      <= '0;
            sbuf      <= '0;
            msb_l     <= 1'b0;
            fin_ok    <= 1'b0;
            fin_err   <= 1'b0;
            out       <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            sync      <= {sync[0], in};
            // Stop verdict is staged one cycle so the strobe lands after IDLE re-entry.
            valid     <= fin_ok;
            frame_err <= fin_err;
            fin_ok    <= 1'b0;
            fin_err   <= 1'b0;
            if (fin_ok) out <= sbuf;
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en && !s) state <= START;
                end
                START: if (cnt == CNT_HALF) begin
                    cnt  <= '0;
                    bcnt <= '0;
                    if (!s) begin
                        state <= DATA;
                        msb_l <= msb_first;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    sbuf <= msb_l ? {sbuf[WIDTH-2:0], s} : {s, sbuf[WIDTH-1:1]};
                    if (bcnt == BIT_LAST) begin
`ifdef SERIAL_DESER_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                PARITY: if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    par_err <= ^{sbuf, s};
                    state   <= STOP;
                end
`endif
                STOP: if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    state <= IDLE;
                    if (stop_good) fin_ok  <= 1'b1;
                    else           fin_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // Dropping enable discards the frame in flight, including a pending verdict.
            if (!en && state != IDLE) begin
                state   <= IDLE;
                cnt     <= '0;
                fin_ok  <= 1'b0;
                fin_err <= 1'b0;
            end
        end
    end
endmodule

// File: doc/serial_deser.md
Name: serial_deser

Overview:
- Serial-to-parallel frame receiver that feeds the parallel-load input of the bidirectional shift register.
- Takes an asynchronous single-bit line idling high and recovers framed words: start bit (0), WIDTH data bits, optional parity bit, stop bit (1).
- Uses a DIV-clock bit period with mid-bit sampling.
- Presents each good word on a parallel bus with a one-cycle valid strobe, suitable for driving the shifter's load enable directly.

Parameters:
- WIDTH, 8: data bits per frame; out bus width.
- DIV, 4: clocks per bit period; legal range 2..255, even values only.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- in  input  1  serial line, idle high, asynchronous to clk.
- en  input  1  receive enable; low forces idle.
- msb_first  input  1  1 = first data bit is out[WIDTH-1]; 0 = first data bit is out[0]. Sampled at start-bit validation and held for the frame.
- out  output  WIDTH  last good received word.
- valid  output  1  one-cycle strobe: out updated this cycle.
- frame_err  output  1  one-cycle strobe: stop (or parity) failure.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset (rst low, asynchronous): out=0, valid=0, frame_err=0, busy=0, FSM=IDLE, bit and clock counters=0, synchronizer flops=1.
- Input path: in passes through a 2-flop synchronizer. All timing below is relative to the synchronized signal s, which lags in by 2 clocks.
- Counter: bit-period counter runs 0..DIV-1. A "sample" occurs when it reaches DIV/2-1 after a restart.
- FSM states: IDLE, START, DATA, PARITY (only with feature), STOP.
- IDLE:
  - If en=1 and s=0, go to START and restart the counter.
  - If en=0, remain in IDLE.
- START:
  - At the sample point, if s=0, latch msb_first and go to DATA.
  - If s=1 at the sample point, treat it as a glitch: return to IDLE, no strobe.
- DATA:
  - Every DIV clocks, sample s into the shift buffer. LSB-first fills from the top and shifts right; MSB-first shifts left.
  - After WIDTH samples, go to PARITY (if enabled) or STOP.
- STOP (sampled one DIV after the last data or parity sample):
  - If s=1 and no parity error, load out and pulse valid in the next cycle.
  - Otherwise out is unchanged and frame_err pulses in the next cycle.
  - Return to IDLE on the sample cycle, so the next start bit can be detected half a bit early for resynchronisation.
- Strobes: valid and frame_err are registered, high for exactly one clock, and never both high.
- Latency: valid rises 2 + DIV/2 + (WIDTH+1)·DIV + 1 clocks after the first clock at which in=0 is sampled (41 for the defaults), plus DIV if parity is enabled.
- en deasserted mid-frame: abort to IDLE on the next clock. No strobe, out unchanged, partial buffer discarded.
- Line stuck low after a frame error: reads as a new start bit and is re-evaluated; no lockup.
- Back-to-back frames with zero idle bits are received without loss.
- busy falls in the same cycle the FSM enters IDLE.

Optional Feature:
- Macro: SERIAL_DESER_PARITY_EN.
- Defined:
  - One even-parity bit follows the data bits, sampled in the PARITY state.
  - A mismatch (XOR of data bits ≠ parity bit) forces frame_err at STOP, even if the stop bit is good.
  - Frame length becomes WIDTH+3 bits.
- Undefined:
  - PARITY state and parity logic are absent.
  - Frame length is WIDTH+2 bits.
  - Port list is identical in both builds.

Test Plan:
- Reset, then en=1, msb_first=0, send 0xA5 LSB-first at DIV=4 -> valid high for one cycle exactly 41 clocks after the falling edge is first sampled, out=0xA5, frame_err=0.
- Same frame with msb_first=1, bit order 1,0,1,0,0,1,0,1 -> out=0xA5. Then send 0x01 MSB-first -> out=0x01.
- Low pulse of 1 clock on in while idle -> no strobe, busy returns to 0 within DIV/2+3 clocks, out unchanged.
- Frame 0x3C with stop bit forced 0 -> frame_err one cycle, valid=0, out retains previous 0xA5.
- Start frame 0xFF, then drop en after 3 data bits; re-enable and send 0x5A -> only one valid strobe, out=0x5A. Repeat, asserting rst mid-frame -> all outputs 0 immediately.
- With SERIAL_DESER_PARITY_EN: 0x07 with parity 1 -> valid, out=0x07. Same word with parity 0 -> frame_err, out unchanged. Two back-to-back frames with no idle gap -> two valid strobes 44 clocks apart.
